// File: rtl/fft_iter_engine.sv
//-----------------------------------------------------------------------------
// fft_iter_engine
//
// Iterative radix-2 decimation-in-time FFT/IFFT engine. One butterfly is
// time-multiplexed over an N-entry complex register file and works in place:
//   LOAD    : N samples stream in and are written at bit-reversed addresses.
//   COMPUTE : (N/2)*log2(N) cycles, one butterfly per cycle.
//   UNLOAD  : N bins stream out in natural order.
//
// Parameters
//   N_POINT     transform size, power of two, 4..64
//   DATA_W      width of each real/imag component (two's complement)
//   FRAC_W      fractional bits of the fixed-point format
//   STAGE_SCALE 1 = every butterfly output is arithmetic-shifted right by 1
//
// Ports
//   clock              single clock, rising edge
//   reset              synchronous, active-low
//   in_valid/in_ready  input handshake (ready only in LOAD)
//   in_real/in_imag    input sample
//   inverse            sampled with the first sample of a frame; 1 = IFFT
//   out_valid/out_ready output handshake (valid only in UNLOAD)
//   out_real/out_imag  output bin X[idx], natural order, 0 when not valid
//   out_last           high with bin N-1
//   busy               high in COMPUTE and UNLOAD
//-----------------------------------------------------------------------------
module fft_iter_engine #(
  parameter int N_POINT     = 8,
  parameter int DATA_W      = 32,
  parameter int FRAC_W      = 16,
  parameter int STAGE_SCALE = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  input  logic              inverse,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic              out_last,
  output logic              busy
);

  localparam int LOG_N  = $clog2(N_POINT);
  localparam int HALF   = N_POINT / 2;
  localparam int BF_W   = LOG_N - 1;
  localparam int PROD_W = 2 * DATA_W;

  localparam logic [LOG_N-1:0] CNT_LAST = LOG_N'(N_POINT - 1);
  localparam logic [LOG_N-1:0] STG_LAST = LOG_N'(LOG_N - 1);
  localparam logic [BF_W-1:0]  BF_LAST  = BF_W'(HALF - 1);

  localparam logic [1:0] ST_LOAD    = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_UNLOAD  = 2'd2;

  localparam real TWO_PI  = 6.283185307179586476925;
  localparam real SCALE_Q = 2.0 ** FRAC_W;

  // Round half away from zero; only evaluated at elaboration.
  function automatic longint round_fix(input real x);
    if (x >= 0.0) begin
      return longint'($floor(x + 0.5));
    end
    return -longint'($floor(-x + 0.5));
  endfunction

  //---------------------------------------------------------------------------
  // State
  //---------------------------------------------------------------------------
  logic [1:0]       state_reg;
  logic [LOG_N-1:0] cnt_reg;     // load counter
  logic [LOG_N-1:0] idx_reg;     // unload counter
  logic [LOG_N-1:0] stage_reg;   // butterfly stage s
  logic [BF_W-1:0]  bf_reg;      // butterfly index b within the stage
  logic             inv_reg;     // inverse flag latched with sample 0

  // Register file rather than block RAM: every butterfly needs two reads
  // and two writes in the same cycle.
  logic [DATA_W-1:0] mem_re [N_POINT];
  logic [DATA_W-1:0] mem_im [N_POINT];

  //---------------------------------------------------------------------------
  // Twiddle table, W^k = C[k] -/+ j*S[k], k = 0..N/2-1
  //---------------------------------------------------------------------------
  logic signed [DATA_W-1:0] cos_tab [HALF];
  logic signed [DATA_W-1:0] sin_tab [HALF];

  generate
    for (genvar gi = 0; gi < HALF; gi++) begin : g_twiddle
      localparam real    ANGLE = TWO_PI * gi / N_POINT;
      localparam longint COS_Q = round_fix(SCALE_Q * $cos(ANGLE));
      localparam longint SIN_Q = round_fix(SCALE_Q * $sin(ANGLE));
      assign cos_tab[gi] = DATA_W'(COS_Q);
      assign sin_tab[gi] = DATA_W'(SIN_Q);
    end
  endgenerate

  //---------------------------------------------------------------------------
  // Load path: sample cnt goes to address bitrev(cnt)
  //---------------------------------------------------------------------------
  logic             in_fire;
  logic [LOG_N-1:0] load_addr;

  assign in_ready = (state_reg == ST_LOAD);
  assign in_fire  = in_valid & in_ready;

  generate
    for (genvar gi = 0; gi < LOG_N; gi++) begin : g_bitrev
      assign load_addr[gi] = cnt_reg[LOG_N-1-gi];
    end
  endgenerate

  //---------------------------------------------------------------------------
  // Butterfly addressing
  //   h = 2^s, t = (b>>s)*2h + (b & (h-1)), u = t + h
  //   k = (b & (h-1)) << (L-1-s)
  //---------------------------------------------------------------------------
  logic [LOG_N-1:0] bf_ext;
  logic [LOG_N-1:0] half_span;
  logic [LOG_N-1:0] low_mask;
  logic [LOG_N-1:0] top_addr;
  logic [LOG_N-1:0] bot_addr;
  logic [BF_W-1:0]  tw_idx;

  assign bf_ext    = {1'b0, bf_reg};
  assign half_span = LOG_N'(1) << stage_reg;
  assign low_mask  = half_span - LOG_N'(1);
  assign top_addr  = ((bf_ext >> stage_reg) << (stage_reg + LOG_N'(1)))
                   | (bf_ext & low_mask);
  assign bot_addr  = top_addr + half_span;
  // (b & (h-1)) < h <= N/2, so k always fits in BF_W bits.
  assign tw_idx    = BF_W'((bf_ext & low_mask) << (STG_LAST - stage_reg));

  //---------------------------------------------------------------------------
  // Butterfly datapath
  //---------------------------------------------------------------------------
  logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im;
  logic signed [DATA_W-1:0] w_re, w_im;
  logic signed [PROD_W-1:0] p_rr, p_ii, p_ir, p_ri;
  logic signed [PROD_W-1:0] s_rr, s_ii, s_ir, s_ri;
  logic signed [DATA_W-1:0] wb_re, wb_im;
  logic signed [DATA_W-1:0] sum_re, sum_im, dif_re, dif_im;
  logic signed [DATA_W-1:0] top_re, top_im, bot_re, bot_im;

  assign a_re = mem_re[top_addr];
  assign a_im = mem_im[top_addr];
  assign b_re = mem_re[bot_addr];
  assign b_im = mem_im[bot_addr];

  // Forward uses the conjugate twiddle (-j*S); inverse uses +j*S.
  assign w_re = cos_tab[tw_idx];
  assign w_im = inv_reg ? sin_tab[tw_idx] : -sin_tab[tw_idx];

  // Full-width products, floor-shifted by FRAC_W, then truncated to DATA_W.
  assign p_rr = PROD_W'(b_re) * PROD_W'(w_re);
  assign p_ii = PROD_W'(b_im) * PROD_W'(w_im);
  assign p_ir = PROD_W'(b_im) * PROD_W'(w_re);
  assign p_ri = PROD_W'(b_re) * PROD_W'(w_im);

  assign s_rr = p_rr >>> FRAC_W;
  assign s_ii = p_ii >>> FRAC_W;
  assign s_ir = p_ir >>> FRAC_W;
  assign s_ri = p_ri >>> FRAC_W;

  assign wb_re = DATA_W'(s_rr) - DATA_W'(s_ii);
  assign wb_im = DATA_W'(s_ir) + DATA_W'(s_ri);

  // All adds wrap modulo 2^DATA_W.
  assign sum_re = a_re + wb_re;
  assign sum_im = a_im + wb_im;
  assign dif_re = a_re - wb_re;
  assign dif_im = a_im - wb_im;

  generate
    if (STAGE_SCALE != 0) begin : g_scale
      assign top_re = sum_re >>> 1;
      assign top_im = sum_im >>> 1;
      assign bot_re = dif_re >>> 1;
      assign bot_im = dif_im >>> 1;
    end else begin : g_no_scale
      assign top_re = sum_re;
      assign top_im = sum_im;
      assign bot_re = dif_re;
      assign bot_im = dif_im;
    end
  endgenerate

  //---------------------------------------------------------------------------
  // Register file writes (not reset; contents are don't-care between frames)
  //---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      if (in_fire) begin
        mem_re[load_addr] <= in_real;
        mem_im[load_addr] <= in_imag;
      end else if (state_reg == ST_COMPUTE) begin
        mem_re[top_addr] <= top_re;
        mem_im[top_addr] <= top_im;
        mem_re[bot_addr] <= bot_re;
        mem_im[bot_addr] <= bot_im;
      end
    end
  end

  //---------------------------------------------------------------------------
  // Control
  //---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg <= ST_LOAD;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      stage_reg <= '0;
      bf_reg    <= '0;
      inv_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_LOAD: begin
          if (in_fire) begin
            if (cnt_reg == '0) begin
              inv_reg <= inverse;
            end
            // Counter wraps to 0 on the last sample, ready for the next frame.
            cnt_reg <= cnt_reg + LOG_N'(1);
            if (cnt_reg == CNT_LAST) begin
              state_reg <= ST_COMPUTE;
            end
          end
        end

        ST_COMPUTE: begin
          if (bf_reg == BF_LAST) begin
            bf_reg <= '0;
            if (stage_reg == STG_LAST) begin
              stage_reg <= '0;
              idx_reg   <= '0;
              state_reg <= ST_UNLOAD;
            end else begin
              stage_reg <= stage_reg + LOG_N'(1);
            end
          end else begin
            bf_reg <= bf_reg + BF_W'(1);
          end
        end

        ST_UNLOAD: begin
          if (out_ready) begin
            idx_reg <= idx_reg + LOG_N'(1);
            if (idx_reg == CNT_LAST) begin
              state_reg <= ST_LOAD;
            end
          end
        end

        default: begin
          state_reg <= ST_LOAD;
        end
      endcase
    end
  end

  //---------------------------------------------------------------------------
  // Outputs
  //---------------------------------------------------------------------------
  assign out_valid = (state_reg == ST_UNLOAD);
  assign busy      = (state_reg != ST_LOAD);
  assign out_real  = out_valid ? mem_re[idx_reg] : '0;
  assign out_imag  = out_valid ? mem_im[idx_reg] : '0;
  assign out_last  = out_valid && (idx_reg == CNT_LAST);

endmodule

// File: tb/tb_fft_iter_engine.sv
// Testbench for fft_iter_engine. Three instances: N=8, N=64 and N=8 with
// per-stage scaling. Expected bins come from a floating-point DFT of the
// stimulus, queued when the frame is sent and compared as bins leave the DUT.
module tb_fft_iter_engine;

  localparam int DW = 32;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          rst_n;
  logic          in_valid;
  logic          inverse;
  logic          out_ready;
  logic [DW-1:0] in_real;
  logic [DW-1:0] in_imag;
  int            sel;   // 0: N=8, 1: N=64, 2: N=8 scaled

  logic          iv [3];
  logic          ir [3];
  logic          ov [3];
  logic          ol [3];
  logic          bz [3];
  logic [DW-1:0] o_re [3];
  logic [DW-1:0] o_im [3];

  assign iv[0] = in_valid && (sel == 0);
  assign iv[1] = in_valid && (sel == 1);
  assign iv[2] = in_valid && (sel == 2);

  fft_iter_engine #(.N_POINT(8), .DATA_W(DW), .FRAC_W(16), .STAGE_SCALE(0)) u_dut8 (
    .clock(clock), .reset(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_real(in_real), .in_imag(in_imag), .inverse(inverse),
    .out_valid(ov[0]), .out_ready(out_ready), .out_real(o_re[0]), .out_imag(o_im[0]),
    .out_last(ol[0]), .busy(bz[0]));

  fft_iter_engine #(.N_POINT(64), .DATA_W(DW), .FRAC_W(16), .STAGE_SCALE(0)) u_dut64 (
    .clock(clock), .reset(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_real(in_real), .in_imag(in_imag), .inverse(inverse),
    .out_valid(ov[1]), .out_ready(out_ready), .out_real(o_re[1]), .out_imag(o_im[1]),
    .out_last(ol[1]), .busy(bz[1]));

  fft_iter_engine #(.N_POINT(8), .DATA_W(DW), .FRAC_W(16), .STAGE_SCALE(1)) u_dut8s (
    .clock(clock), .reset(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_real(in_real), .in_imag(in_imag), .inverse(inverse),
    .out_valid(ov[2]), .out_ready(out_ready), .out_real(o_re[2]), .out_imag(o_im[2]),
    .out_last(ol[2]), .busy(bz[2]));

  logic          mon_in_ready, mon_out_valid, mon_out_last, mon_busy;
  logic [DW-1:0] mon_out_real, mon_out_imag;

  always_comb begin
    mon_in_ready  = ir[0];
    mon_out_valid = ov[0];
    mon_out_last  = ol[0];
    mon_busy      = bz[0];
    mon_out_real  = o_re[0];
    mon_out_imag  = o_im[0];
    if (sel == 1) begin
      mon_in_ready  = ir[1];
      mon_out_valid = ov[1];
      mon_out_last  = ol[1];
      mon_busy      = bz[1];
      mon_out_real  = o_re[1];
      mon_out_imag  = o_im[1];
    end else if (sel == 2) begin
      mon_in_ready  = ir[2];
      mon_out_valid = ov[2];
      mon_out_last  = ol[2];
      mon_busy      = bz[2];
      mon_out_real  = o_re[2];
      mon_out_imag  = o_im[2];
    end
  end

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          last;
    int            bin;
    int            tol;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            stim_re [64];
  int            stim_im [64];
  logic [DW-1:0] obs_re [64];
  logic [DW-1:0] obs_im [64];

  function automatic logic [DW-1:0] round_int(input real x);
    if (x >= 0.0) return DW'($rtoi(x + 0.5));
    return DW'(-$rtoi(-x + 0.5));
  endfunction

  // Reference DFT of stim_*; result divided by 2^sh.
  task automatic push_dft(input int n, input bit inv, input int sh, input int tol);
    real  th, sr, si, xr, xi, c, s;
    exp_t e;
    for (int k = 0; k < n; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int m = 0; m < n; m++) begin
        th = 6.283185307179586 * m * k / n;
        c  = $cos(th);
        s  = $sin(th);
        xr = real'(stim_re[m]);
        xi = real'(stim_im[m]);
        if (!inv) begin
          sr += xr * c + xi * s;
          si += xi * c - xr * s;
        end else begin
          sr += xr * c - xi * s;
          si += xi * c + xr * s;
        end
      end
      e.re   = round_int(sr / (2.0 ** sh));
      e.im   = round_int(si / (2.0 ** sh));
      e.last = (k == n - 1);
      e.bin  = k;
      e.tol  = tol;
      exp_q.push_back(e);
    end
  endtask

  task automatic set_stim(input int kind);
    for (int i = 0; i < 64; i++) begin
      stim_re[i] = 0;
      stim_im[i] = 0;
    end
    case (kind)
      0: stim_re[0] = 32'h00010000;
      1: stim_re[1] = 32'h00010000;
      default: for (int i = 0; i < 64; i++) stim_re[i] = 32'h00010000;
    endcase
  endtask

  // Scoreboard: pop one expectation for the bin handshaking at the next edge.
  task automatic score_output();
    exp_t e;
    int   dre, dim;
    bit   bad;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_output: got re=%h im=%h, required no output", mon_out_real, mon_out_imag);
      return;
    end
    e   = exp_q.pop_front();
    dre = $signed(mon_out_real) - $signed(e.re);
    dim = $signed(mon_out_imag) - $signed(e.im);
    bad = $isunknown({mon_out_real, mon_out_imag, mon_out_last}) ||
          dre > e.tol || dre < -e.tol || dim > e.tol || dim < -e.tol ||
          (mon_out_last !== e.last);
    obs_re[e.bin] = mon_out_real;
    obs_im[e.bin] = mon_out_imag;
    if (bad) begin
      errors++;
      $display("FAIL bin_%0d: got re=%h im=%h last=%b, required re=%h im=%h last=%b (tol %0d)",
               e.bin, mon_out_real, mon_out_imag, mon_out_last, e.re, e.im, e.last, e.tol);
    end else begin
      $display("dut%0d bin %0d re=%h im=%h last=%b", sel, e.bin, mon_out_real, mon_out_imag, mon_out_last);
    end
  endtask

  // One clock: score at the falling edge, return 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clock);
    if (mon_out_valid === 1'b1 && out_ready === 1'b1) score_output();
    @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input int n, input logic inv);
    int w;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_real  = stim_re[i];
      in_imag  = stim_im[i];
      inverse  = (i == 0) ? inv : ~inv;  // only sample 0 should be latched
      w = 0;
      while (mon_in_ready !== 1'b1 && w < 1000) begin
        tick();
        w++;
      end
      if (w == 1000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready=%b, required 1", mon_in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    inverse  = 1'b0;
  endtask

  task automatic wait_first_output(output int lat, output bit rdy_hi, output bit data_nz);
    lat     = 0;
    rdy_hi  = 0;
    data_nz = 0;
    while (lat < 1000) begin
      tick();
      lat++;
      if (mon_out_valid === 1'b1) return;
      if (mon_in_ready !== 1'b0) rdy_hi = 1;
      if (mon_out_real !== '0 || mon_out_imag !== '0) data_nz = 1;
    end
    lat = -1;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 2000) begin
      tick();
      w++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d bins outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    inverse = 1'b0;
    out_ready = 1'b1;
    in_real = '0;
    in_imag = '0;
    sel = 0;
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ir[d] !== 1'b1 || ov[d] !== 1'b0 || ol[d] !== 1'b0 || bz[d] !== 1'b0 ||
          o_re[d] !== '0 || o_im[d] !== '0) begin
        errors++;
        $display("FAIL reset_state dut%0d: in_ready=%b out_valid=%b out_last=%b busy=%b re=%h im=%h, required 1 0 0 0 0 0",
                 d, ir[d], ov[d], ol[d], bz[d], o_re[d], o_im[d]);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_impulse(input int dut, input int n, input int c_exp);
    int lat;
    bit rdy_hi, data_nz;
    sel = dut;
    set_stim(0);
    push_dft(n, 1'b0, 0, 0);
    send_frame(n, 1'b0);
    checks++;
    if (mon_in_ready !== 1'b0 || mon_busy !== 1'b1) begin
      errors++;
      $display("FAIL impulse_after_load: in_ready=%b busy=%b, required 0 1", mon_in_ready, mon_busy);
    end
    wait_first_output(lat, rdy_hi, data_nz);
    checks++;
    if (lat !== c_exp) begin
      errors++;
      $display("FAIL impulse_latency N=%0d: got %0d cycles, required %0d", n, lat, c_exp);
    end
    checks++;
    if (rdy_hi !== 1'b0 || data_nz !== 1'b0) begin
      errors++;
      $display("FAIL compute_outputs: in_ready_seen=%b data_nonzero=%b, required 0 0", rdy_hi, data_nz);
    end
    wait_drain();
    checks++;
    if (mon_in_ready !== 1'b1 || mon_busy !== 1'b0 || mon_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL impulse_return_load: in_ready=%b busy=%b out_valid=%b, required 1 0 0",
               mon_in_ready, mon_busy, mon_out_valid);
    end
  endtask

  task automatic test_dc();
    sel = 0;
    set_stim(2);
    push_dft(8, 1'b0, 0, 0);
    send_frame(8, 1'b0);
    wait_drain();
    checks++;
    if (obs_re[0] !== 32'h00080000 || obs_im[0] !== 32'h0) begin
      errors++;
      $display("FAIL dc_x0: got %h %h, required 00080000 00000000", obs_re[0], obs_im[0]);
    end
    sel = 2;
    push_dft(8, 1'b0, 3, 0);
    send_frame(8, 1'b0);
    wait_drain();
    checks++;
    if (obs_re[0] !== 32'h00010000 || obs_im[0] !== 32'h0) begin
      errors++;
      $display("FAIL dc_scaled_x0: got %h %h, required 00010000 00000000", obs_re[0], obs_im[0]);
    end
  endtask

  task automatic test_shift(input bit inv);
    logic [DW-1:0] want_im2;
    sel = 0;
    set_stim(1);
    push_dft(8, inv, 0, 1);
    send_frame(8, inv);
    wait_drain();
    want_im2 = inv ? 32'h00010000 : 32'hFFFF0000;
    checks++;
    if (obs_re[2] !== 32'h0 || obs_im[2] !== want_im2) begin
      errors++;
      $display("FAIL shift_x2 inv=%0d: got %h %h, required 00000000 %h", inv, obs_re[2], obs_im[2], want_im2);
    end
    checks++;
    if ($signed(obs_re[1]) < 32'sh0000B504 || $signed(obs_re[1]) > 32'sh0000B506) begin
      errors++;
      $display("FAIL shift_x1_re inv=%0d: got %h, required 0000B505 +/-1", inv, obs_re[1]);
    end
  endtask

  task automatic test_backpressure();
    int            lat;
    bit            rdy_hi, data_nz;
    logic [DW-1:0] h_re, h_im;
    logic          h_last;
    sel = 0;
    set_stim(1);
    push_dft(8, 1'b0, 0, 1);
    out_ready = 1'b0;
    send_frame(8, 1'b0);
    wait_first_output(lat, rdy_hi, data_nz);
    checks++;
    if (rdy_hi !== 1'b0 || lat !== 12) begin
      errors++;
      $display("FAIL bp_compute: in_ready_seen=%b latency=%0d, required 0 12", rdy_hi, lat);
    end
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    checks++;
    if (exp_q.size() !== 5) begin
      errors++;
      $display("FAIL bp_position: %0d bins left, required 5", exp_q.size());
    end
    h_re = mon_out_real;
    h_im = mon_out_imag;
    h_last = mon_out_last;
    for (int c = 0; c < 5; c++) begin
      in_valid = (c % 2 == 0);
      in_real  = 32'h7EAD0000;
      tick();
      checks++;
      if (mon_out_valid !== 1'b1 || mon_out_real !== h_re || mon_out_imag !== h_im ||
          mon_out_last !== h_last || mon_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: valid=%b re=%h im=%h last=%b in_ready=%b, required 1 %h %h %b 0",
                 c, mon_out_valid, mon_out_real, mon_out_imag, mon_out_last, mon_in_ready, h_re, h_im, h_last);
      end
    end
    in_valid = 1'b0;
    in_real  = '0;
    out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    sel = 0;
    set_stim(2);
    send_frame(8, 1'b0);
    repeat (5) tick();   // now inside stage 1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (mon_in_ready !== 1'b1 || mon_out_valid !== 1'b0 || mon_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
               mon_in_ready, mon_out_valid, mon_busy);
    end
    test_impulse(0, 8, 12);
  endtask

  initial begin
    test_reset();
    test_impulse(0, 8, 12);
    test_dc();
    test_shift(1'b0);
    test_shift(1'b1);
    test_backpressure();
    test_reset_mid();
    test_impulse(1, 64, 192);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
